// File: rtl/glitch_filter.sv
// Conditions the asynchronous single-bit output of the delay network: synchronises it,
// rejects short pulses, emits edge strobes, measures accepted high pulses and counts glitches.
module glitch_filter #(
    parameter int STABLE_CYCLES = 4,
    parameter int WIDTH_BITS    = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  en,
    output logic                  dout,
    output logic                  rise,
    output logic                  fall,
    output logic [WIDTH_BITS-1:0] width,
    output logic                  width_valid,
    output logic [7:0]            glitch_cnt
);

    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

    function automatic logic [WIDTH_BITS-1:0] sat_inc_width(input logic [WIDTH_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [7:0] sat_inc_glitch(input logic [7:0] v);
        return (&v) ? v : v + 8'd1;
    endfunction

    logic                  sync0;
    logic                  sync1;
    state_t                state;
    state_t                state_n;
    logic [7:0]            cnt;
    logic [7:0]            cnt_n;
    logic                  dout_n;
    logic                  rise_n;
    logic                  fall_n;
    logic                  width_valid_n;
    logic [WIDTH_BITS-1:0] width_n;
    logic [WIDTH_BITS-1:0] wcnt;
    logic [WIDTH_BITS-1:0] wcnt_n;
    logic [7:0]            glitch_cnt_n;
    logic                  high_now;
    logic                  high_next;

    // Stage: two-flop synchroniser, free running regardless of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= din;
            sync1 <= sync0;
        end
    end

    // Stage: stability FSM and pulse bookkeeping
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        rise_n        = 1'b0;
        fall_n        = 1'b0;
        width_valid_n = 1'b0;
        width_n       = width;
        glitch_cnt_n  = glitch_cnt;

        case (state)
            LOW: begin
                if (en && sync1) begin
                    state_n = CHK_HIGH;
                    cnt_n   = 8'd1;
                end
            end
            CHK_HIGH: begin
                // An en drop wins over a simultaneous reversal, so no glitch is counted
                if (!en) begin
                    state_n = LOW;
                end else if (!sync1) begin
                    state_n      = LOW;
                    glitch_cnt_n = sat_inc_glitch(glitch_cnt);
                end else if (cnt == CNT_LAST) begin
                    state_n = HIGH;
                    rise_n  = 1'b1;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            HIGH: begin
                if (en && !sync1) begin
                    state_n = CHK_LOW;
                    cnt_n   = 8'd1;
                end
            end
            CHK_LOW: begin
                if (!en) begin
                    state_n = HIGH;
                end else if (sync1) begin
                    state_n      = HIGH;
                    glitch_cnt_n = sat_inc_glitch(glitch_cnt);
                end else if (cnt == CNT_LAST) begin
                    state_n       = LOW;
                    fall_n        = 1'b1;
                    width_valid_n = 1'b1;
                    width_n       = wcnt;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                state_n = LOW;
            end
        endcase
    end

    assign high_now  = (state == HIGH) || (state == CHK_LOW);
    assign high_next = (state_n == HIGH) || (state_n == CHK_LOW);
    assign dout_n    = high_next;

    // wcnt ends a pulse holding exactly the number of cycles dout was high
    always_comb begin
        wcnt_n = wcnt;
        if (!high_now && high_next) begin
            wcnt_n = {{(WIDTH_BITS-1){1'b0}}, 1'b1};
        end else if (high_now && high_next) begin
            wcnt_n = sat_inc_width(wcnt);
        end
    end

    // Stage: registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOW;
            cnt         <= 8'd0;
            dout        <= 1'b0;
            rise        <= 1'b0;
            fall        <= 1'b0;
            width_valid <= 1'b0;
            width       <= '0;
            wcnt        <= '0;
            glitch_cnt  <= 8'd0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            dout        <= dout_n;
            rise        <= rise_n;
            fall        <= fall_n;
            width_valid <= width_valid_n;
            width       <= width_n;
            wcnt        <= wcnt_n;
            glitch_cnt  <= glitch_cnt_n;
        end
    end

endmodule
